// File: rtl/control_unit.sv
// control_unit: multicycle MIPS-subset control FSM.
// Decodes the instruction held in the instruction register and drives every datapath
// select, ALU/shifter/load/store size code and write enable through the
// FETCH -> DECODE -> EXECUTE (-> MEMORY -> WRITEBACK) sequence. MULT/DIV park in MDWAIT.
// EXCEPTION holds for three cycles and then jumps to the exception vector.
// Optional build macro: CU_OVERFLOW_TRAP_EN. When it is defined, signed overflow during
// ADD/ADDI/SUB suppresses the write and traps. When it is undefined, overflow is ignored.
module control_unit (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [31:0] instruction,
  input  logic        zero_flag,
  input  logic        overflow_flag,
  input  logic        div_zero,
  input  logic        mult_done,
  input  logic        div_done,
  output logic [1:0]  mux_a,
  output logic [1:0]  mux_b,
  output logic [1:0]  mux_alu_1,
  output logic [1:0]  mux_alu_2,
  output logic        mux_shift_amt,
  output logic        mux_shift_src,
  output logic [1:0]  mux_pc,
  output logic        mux_address,
  output logic [1:0]  mux_wd_memory,
  output logic [1:0]  mux_wd_registers,
  output logic [1:0]  mux_wr_registers,
  output logic        mux_extend,
  output logic        mux_high,
  output logic        mux_low,
  output logic [3:0]  alu_control,
  output logic [1:0]  shift_control,
  output logic [1:0]  load_size_control,
  output logic [1:0]  store_size_control,
  output logic        pc_write_enable,
  output logic        instruction_write,
  output logic        memory_write,
  output logic        register_write,
  output logic        hi_write,
  output logic        lo_write,
  output logic [1:0]  exception_control,
  output logic [2:0]  current_state,
  output logic [3:0]  counter
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_MDWAIT    = 3'd5,
    S_EXCEPTION = 3'd6,
    S_UNUSED    = 3'd7
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_SLLM = 6'h1C;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;
  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_MULT = 6'h18, FN_DIV = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_SUB  = 6'h22, FN_AND = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  // ALU codes
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
  // Exception causes
  localparam logic [1:0] EXC_OVF = 2'b01, EXC_OPC = 2'b10, EXC_DIV0 = 2'b11;

  state_t      state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic [1:0]  exc_q, exc_d;

  logic [5:0]  opcode, funct;
  logic        is_load, is_store, is_mem, op_supported, is_arith;
  logic [1:0]  size_code;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  assign is_load  = (opcode == OP_LW) || (opcode == OP_LH) || (opcode == OP_LB);
  assign is_store = (opcode == OP_SW) || (opcode == OP_SH) || (opcode == OP_SB);
  assign is_mem   = is_load || is_store || (opcode == OP_SLLM);
  // Instructions whose signed overflow is architecturally meaningful
  assign is_arith = (opcode == OP_ADDI) ||
                    ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)));

  // Word/half/byte code shared by loads and stores
  assign size_code = ((opcode == OP_LH) || (opcode == OP_SH)) ? 2'b01 :
                     ((opcode == OP_LB) || (opcode == OP_SB)) ? 2'b10 : 2'b00;

  assign op_supported = is_mem || (opcode == OP_RTYPE) || (opcode == OP_J) ||
                        (opcode == OP_JAL) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                        (opcode == OP_ADDI) || (opcode == OP_LUI);

  // The state and the counter are forced to zero whenever reset is asserted.
  assign current_state = reset_in ? 3'd0 : state_q;
  assign counter       = reset_in ? 4'd0 : counter_q;

  // State, dwell counter and latched exception cause
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q   <= S_FETCH;
      counter_q <= 4'd0;
      exc_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      exc_q     <= exc_d;
    end
  end

  // The counter restarts on any state change and saturates at 15.
  always_comb begin
    if (state_d != state_q)   counter_d = 4'd0;
    else if (counter_q == 4'hF) counter_d = 4'hF;
    else                      counter_d = counter_q + 4'd1;
  end

  // Next state and every control output. All outputs are zero while reset is asserted.
  always_comb begin
    state_d            = state_q;
    exc_d              = exc_q;
    mux_a              = 2'b00;
    mux_b              = 2'b00;
    mux_alu_1          = 2'b00;
    mux_alu_2          = 2'b00;
    mux_shift_amt      = 1'b0;
    mux_shift_src      = 1'b0;
    mux_pc             = 2'b00;
    mux_address        = 1'b0;
    mux_wd_memory      = 2'b00;
    mux_wd_registers   = 2'b00;
    mux_wr_registers   = 2'b00;
    mux_extend         = 1'b0;
    mux_high           = 1'b0;
    mux_low            = 1'b0;
    alu_control        = 4'b0000;
    shift_control      = 2'b00;
    load_size_control  = 2'b00;
    store_size_control = 2'b00;
    pc_write_enable    = 1'b0;
    instruction_write  = 1'b0;
    memory_write       = 1'b0;
    register_write     = 1'b0;
    hi_write           = 1'b0;
    lo_write           = 1'b0;
    exception_control  = 2'b00;

    if (!reset_in) begin
      case (state_q)
        S_FETCH: begin
          mux_address       = 1'b1;
          instruction_write = 1'b1;
          mux_alu_1         = 2'b01;
          mux_alu_2         = 2'b10;
          alu_control       = ALU_ADD;
          mux_pc            = 2'b00;
          pc_write_enable   = 1'b1;
          state_d           = S_DECODE;
        end

        S_DECODE: begin
          if (op_supported) begin
            state_d = S_EXECUTE;
          end else begin
            state_d = S_EXCEPTION;
            exc_d   = EXC_OPC;
          end
        end

        S_EXECUTE: begin
          state_d = S_FETCH;
          if (is_mem) begin
            // Effective address A + sext(imm)
            alu_control = ALU_ADD;
            mux_alu_2   = 2'b01;
            mux_b       = 2'b01;
            mux_extend  = 1'b0;
            state_d     = S_MEMORY;
          end else begin
            case (opcode)
              OP_ADDI: begin
                alu_control      = ALU_ADD;
                mux_alu_2        = 2'b01;
                mux_b            = 2'b01;
                mux_extend       = 1'b0;
                mux_wr_registers = 2'b00;
                mux_wd_registers = 2'b00;
                register_write   = 1'b1;
              end
              OP_LUI: begin
                mux_wd_registers = 2'b10;
                mux_wr_registers = 2'b00;
                register_write   = 1'b1;
              end
              OP_BEQ, OP_BNE: begin
                alu_control     = ALU_SUB;
                mux_pc          = 2'b01;
                pc_write_enable = (opcode == OP_BEQ) ? zero_flag : !zero_flag;
              end
              OP_J: begin
                mux_pc          = 2'b10;
                pc_write_enable = 1'b1;
              end
              OP_JAL: begin
                // Link: PC (already PC+4) routed through the ALU into $31
                mux_pc           = 2'b10;
                pc_write_enable  = 1'b1;
                mux_alu_1        = 2'b01;
                alu_control      = ALU_ADD;
                mux_wr_registers = 2'b10;
                mux_wd_registers = 2'b00;
                register_write   = 1'b1;
              end
              OP_RTYPE: begin
                case (funct)
                  FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                    case (funct)
                      FN_ADD:  alu_control = ALU_ADD;
                      FN_SUB:  alu_control = ALU_SUB;
                      FN_AND:  alu_control = ALU_AND;
                      FN_OR:   alu_control = ALU_OR;
                      default: alu_control = ALU_SLT;
                    endcase
                    mux_wr_registers = 2'b01;
                    mux_wd_registers = 2'b00;
                    register_write   = 1'b1;
                  end
                  FN_SLL, FN_SRL, FN_SRA: begin
                    // Shift rt by shamt
                    mux_shift_src    = 1'b1;
                    mux_shift_amt    = 1'b0;
                    shift_control    = (funct == FN_SLL) ? 2'b01 :
                                       (funct == FN_SRL) ? 2'b10 : 2'b11;
                    mux_wr_registers = 2'b01;
                    mux_wd_registers = 2'b11;
                    register_write   = 1'b1;
                  end
                  FN_JR: begin
                    mux_pc          = 2'b10;
                    pc_write_enable = 1'b1;
                  end
                  FN_MFHI, FN_MFLO: begin
                    mux_wr_registers = 2'b01;
                    mux_wd_registers = 2'b11;
                    register_write   = 1'b1;
                  end
                  FN_MULT, FN_DIV: state_d = S_MDWAIT;
                  default: ;
                endcase
              end
              default: ;
            endcase
`ifdef CU_OVERFLOW_TRAP_EN
            if (is_arith && overflow_flag) begin
              register_write = 1'b0;
              state_d        = S_EXCEPTION;
              exc_d          = EXC_OVF;
            end
`endif
          end
        end

        S_MEMORY: begin
          mux_address = 1'b0;
          state_d     = S_FETCH;
          if (is_store) begin
            memory_write       = 1'b1;
            mux_wd_memory      = 2'b00;
            store_size_control = size_code;
          end else if (is_load) begin
            register_write     = 1'b1;
            mux_wd_registers   = 2'b01;
            mux_wr_registers   = 2'b00;
            load_size_control  = size_code;
          end else begin
            // SLLM: read the shift amount word, shift happens next cycle
            load_size_control  = 2'b00;
            state_d            = S_WRITEBACK;
          end
        end

        S_WRITEBACK: begin
          mux_shift_src    = 1'b1;
          mux_shift_amt    = 1'b1;
          shift_control    = 2'b01;
          mux_wd_registers = 2'b11;
          mux_wr_registers = 2'b00;
          register_write   = 1'b1;
          state_d          = S_FETCH;
        end

        S_MDWAIT: begin
          if (div_zero) begin
            state_d = S_EXCEPTION;
            exc_d   = EXC_DIV0;
          end else if (mult_done) begin
            hi_write = 1'b1;
            lo_write = 1'b1;
            state_d  = S_FETCH;
          end else if (div_done) begin
            hi_write = 1'b1;
            lo_write = 1'b1;
            mux_high = 1'b1;
            mux_low  = 1'b1;
            state_d  = S_FETCH;
          end
        end

        S_EXCEPTION: begin
          exception_control = exc_q;
          if (counter_q >= 4'd2) begin
            mux_pc          = 2'b11;
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
          end
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit.
// Edge k means the k-th rising edge after reset release. The bench samples the
// combinational outputs at the preceding falling edge, so the sampled values are the
// ones the FSM presents on edge k.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] instruction;
  logic        zero_flag, overflow_flag, div_zero, mult_done, div_done;
  logic [1:0]  mux_a, mux_b, mux_alu_1, mux_alu_2, mux_pc, mux_wd_memory;
  logic [1:0]  mux_wd_registers, mux_wr_registers, shift_control;
  logic [1:0]  load_size_control, store_size_control, exception_control;
  logic        mux_shift_amt, mux_shift_src, mux_address, mux_extend, mux_high, mux_low;
  logic        pc_write_enable, instruction_write, memory_write, register_write;
  logic        hi_write, lo_write;
  logic [3:0]  alu_control, counter;
  logic [2:0]  current_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset_in(reset_in), .instruction(instruction),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .div_zero(div_zero),
    .mult_done(mult_done), .div_done(div_done),
    .mux_a(mux_a), .mux_b(mux_b), .mux_alu_1(mux_alu_1), .mux_alu_2(mux_alu_2),
    .mux_shift_amt(mux_shift_amt), .mux_shift_src(mux_shift_src), .mux_pc(mux_pc),
    .mux_address(mux_address), .mux_wd_memory(mux_wd_memory),
    .mux_wd_registers(mux_wd_registers), .mux_wr_registers(mux_wr_registers),
    .mux_extend(mux_extend), .mux_high(mux_high), .mux_low(mux_low),
    .alu_control(alu_control), .shift_control(shift_control),
    .load_size_control(load_size_control), .store_size_control(store_size_control),
    .pc_write_enable(pc_write_enable), .instruction_write(instruction_write),
    .memory_write(memory_write), .register_write(register_write),
    .hi_write(hi_write), .lo_write(lo_write), .exception_control(exception_control),
    .current_state(current_state), .counter(counter)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset for one edge with the instruction applied, then release. On return the
  // outputs reflect edge 0.
  task automatic begin_op(input logic [31:0] instr);
    @(negedge clk);
    reset_in = 1'b1;
    instruction = instr;
    zero_flag = 0; overflow_flag = 0; div_zero = 0; mult_done = 0; div_done = 0;
    @(negedge clk);
    reset_in = 1'b0;
    #1;
  endtask

  // Advance to the sampling point for the next edge.
  task automatic next_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic go_to_edge(input int k);
    for (int i = 0; i < k; i++) next_edge();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1;
    instruction = 32'h0;
    zero_flag = 0; overflow_flag = 0; div_zero = 0; mult_done = 0; div_done = 0;

    // Reset state: all outputs low while reset is asserted
    @(posedge clk); #1;
    check("rst_state", current_state, 3'd0);
    check("rst_counter", counter, 4'd0);
    check("rst_iw", instruction_write, 1'b0);
    check("rst_pcw", pc_write_enable, 1'b0);
    $display("reset: state=%0d counter=%0d", current_state, counter);

    // ADDI
    begin_op(32'h20010064);
    check("fetch_state", current_state, 3'd0);
    check("fetch_counter", counter, 4'd0);
    check("fetch_iw", instruction_write, 1'b1);
    check("fetch_addr", mux_address, 1'b1);
    check("fetch_alu1", mux_alu_1, 2'b01);
    check("fetch_alu2", mux_alu_2, 2'b10);
    check("fetch_alu", alu_control, 4'b0010);
    check("fetch_pcw", pc_write_enable, 1'b1);
    next_edge();
    check("decode_state", current_state, 3'd1);
    check("decode_pcw", pc_write_enable, 1'b0);
    check("decode_iw", instruction_write, 1'b0);
    next_edge();
    check("addi_state", current_state, 3'd2);
    check("addi_alu", alu_control, 4'b0010);
    check("addi_ext", mux_extend, 1'b0);
    check("addi_rw", register_write, 1'b1);
    check("addi_alu2", mux_alu_2, 2'b01);
    check("addi_wr", mux_wr_registers, 2'b00);
    check("addi_muxb", mux_b, 2'b01);
    next_edge();
    check("addi_back", current_state, 3'd0);
    $display("ADDI 20010064 done");

    // LUI
    begin_op(32'h3C011234);
    go_to_edge(2);
    check("lui_rw", register_write, 1'b1);
    check("lui_wd", mux_wd_registers, 2'b10);
    check("lui_wr", mux_wr_registers, 2'b00);
    next_edge();
    check("lui_back", current_state, 3'd0);
    $display("LUI 3C011234 done");

    // LW and LB
    begin_op(32'h8C410000);
    go_to_edge(2);
    check("lw_ex_alu", alu_control, 4'b0010);
    check("lw_ex_alu2", mux_alu_2, 2'b01);
    next_edge();
    check("lw_state", current_state, 3'd3);
    check("lw_size", load_size_control, 2'b00);
    check("lw_mw", memory_write, 1'b0);
    check("lw_rw", register_write, 1'b1);
    check("lw_wd", mux_wd_registers, 2'b01);
    check("lw_addr", mux_address, 1'b0);
    next_edge();
    check("lw_back", current_state, 3'd0);
    $display("LW 8C410000 done");

    begin_op(32'h80410000);
    go_to_edge(3);
    check("lb_state", current_state, 3'd3);
    check("lb_size", load_size_control, 2'b10);
    check("lb_rw", register_write, 1'b1);
    $display("LB 80410000 done");

    // SW and SB
    begin_op(32'hAC410000);
    go_to_edge(3);
    check("sw_state", current_state, 3'd3);
    check("sw_size", store_size_control, 2'b00);
    check("sw_mw", memory_write, 1'b1);
    check("sw_rw", register_write, 1'b0);
    $display("SW AC410000 done");

    begin_op(32'hA0410000);
    go_to_edge(3);
    check("sb_state", current_state, 3'd3);
    check("sb_size", store_size_control, 2'b10);
    check("sb_mw", memory_write, 1'b1);
    check("sb_rw", register_write, 1'b0);
    $display("SB A0410000 done");

    // BEQ taken / not taken
    begin_op(32'h10220004);
    go_to_edge(2);
    zero_flag = 1'b1; #1;
    check("beq_z1_pcw", pc_write_enable, 1'b1);
    check("beq_alu", alu_control, 4'b0110);
    check("beq_muxpc", mux_pc, 2'b01);
    zero_flag = 1'b0; #1;
    check("beq_z0_pcw", pc_write_enable, 1'b0);
    $display("BEQ 10220004 done");

    // BNE taken / not taken
    begin_op(32'h14220004);
    go_to_edge(2);
    zero_flag = 1'b0; #1;
    check("bne_z0_pcw", pc_write_enable, 1'b1);
    check("bne_muxpc", mux_pc, 2'b01);
    zero_flag = 1'b1; #1;
    check("bne_z1_pcw", pc_write_enable, 1'b0);
    $display("BNE 14220004 done");

    // SLLM full walk through WRITEBACK
    begin_op(32'h70220004);
    check("sllm_s0", current_state, 3'd0);
    next_edge(); check("sllm_s1", current_state, 3'd1);
    next_edge(); check("sllm_s2", current_state, 3'd2);
    next_edge();
    check("sllm_s3", current_state, 3'd3);
    check("sllm_mem_size", load_size_control, 2'b00);
    check("sllm_mem_mw", memory_write, 1'b0);
    check("sllm_mem_rw", register_write, 1'b0);
    next_edge();
    check("sllm_s4", current_state, 3'd4);
    check("sllm_shift", shift_control, 2'b01);
    check("sllm_rw", register_write, 1'b1);
    check("sllm_wd", mux_wd_registers, 2'b11);
    check("sllm_src", mux_shift_src, 1'b1);
    check("sllm_amt", mux_shift_amt, 1'b1);
    next_edge(); check("sllm_back", current_state, 3'd0);
    $display("SLLM 70220004 done");

    // Reset while in the middle of SLLM
    begin_op(32'h70220004);
    go_to_edge(3);
    reset_in = 1'b1; #1;
    check("midrst_rw", register_write, 1'b0);
    @(posedge clk); #1;
    check("midrst_state", current_state, 3'd0);
    check("midrst_counter", counter, 4'd0);
    @(negedge clk);
    reset_in = 1'b0; #1;
    check("midrst_fetch", current_state, 3'd0);
    check("midrst_iw", instruction_write, 1'b1);
    $display("SLLM mid-op reset done");

    // Unsupported opcode: three-cycle exception then vector
    begin_op(32'hFC000000);
    go_to_edge(2);
    check("exc_state", current_state, 3'd6);
    check("exc_cnt0", counter, 4'd0);
    check("exc_code", exception_control, 2'b10);
    check("exc_pcw0", pc_write_enable, 1'b0);
    go_to_edge(2);
    check("exc_cnt2", counter, 4'd2);
    check("exc_muxpc", mux_pc, 2'b11);
    check("exc_pcw2", pc_write_enable, 1'b1);
    next_edge(); check("exc_back", current_state, 3'd0);
    $display("BADOP FC000000 done");

    // MULT: MDWAIT with counter saturation
    begin_op(32'h00220018);
    go_to_edge(3);
    check("mult_wait", current_state, 3'd5);
    check("mult_cnt0", counter, 4'd0);
    go_to_edge(20);
    check("mult_still", current_state, 3'd5);
    check("mult_sat", counter, 4'd15);
    check("mult_hiw0", hi_write, 1'b0);
    mult_done = 1'b1; #1;
    check("mult_hiw", hi_write, 1'b1);
    check("mult_low", lo_write, 1'b1);
    check("mult_muxh", mux_high, 1'b0);
    next_edge(); check("mult_back", current_state, 3'd0);
    $display("MULT 00220018 done");

    // DIV completes normally
    begin_op(32'h0022001A);
    go_to_edge(3);
    div_done = 1'b1; #1;
    check("div_hiw", hi_write, 1'b1);
    check("div_muxh", mux_high, 1'b1);
    check("div_muxl", mux_low, 1'b1);
    next_edge(); check("div_back", current_state, 3'd0);
    $display("DIV 0022001A done");

    // DIV by zero traps
    begin_op(32'h0022001A);
    go_to_edge(3);
    div_zero = 1'b1; #1;
    check("div0_hiw", hi_write, 1'b0);
    next_edge();
    check("div0_state", current_state, 3'd6);
    check("div0_code", exception_control, 2'b11);
    $display("DIV zero-divisor done");

    // ADD with overflow
    begin_op(32'h00221820);
    go_to_edge(2);
    overflow_flag = 1'b1; #1;
    check("add_alu", alu_control, 4'b0010);
    check("add_wr", mux_wr_registers, 2'b01);
`ifdef CU_OVERFLOW_TRAP_EN
    check("add_ovf_rw", register_write, 1'b0);
    next_edge();
    check("add_ovf_state", current_state, 3'd6);
    check("add_ovf_code", exception_control, 2'b01);
`else
    check("add_ovf_rw", register_write, 1'b1);
    next_edge();
    check("add_ovf_state", current_state, 3'd0);
`endif
    $display("ADD 00221820 overflow done");

    // SUB and SLT ALU codes
    begin_op(32'h00221822);
    go_to_edge(2);
    check("sub_alu", alu_control, 4'b0110);
    $display("SUB 00221822 done");
    begin_op(32'h0022182A);
    go_to_edge(2);
    check("slt_alu", alu_control, 4'b0111);
    $display("SLT 0022182A done");

    // J and JAL
    begin_op(32'h08000010);
    go_to_edge(2);
    check("j_muxpc", mux_pc, 2'b10);
    check("j_pcw", pc_write_enable, 1'b1);
    check("j_rw", register_write, 1'b0);
    $display("J 08000010 done");
    begin_op(32'h0C000010);
    go_to_edge(2);
    check("jal_muxpc", mux_pc, 2'b10);
    check("jal_wr", mux_wr_registers, 2'b10);
    check("jal_rw", register_write, 1'b1);
    $display("JAL 0C000010 done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
